acc_offload_responder: RTL
==========================

ACC_OFFLOAD_RESPONDER -- requirements
Module: acc_offload_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32: operand/result width (>=32).
REQ-002 SHALL have parameter IdWidth, default 4: request tag width.
REQ-003 SHALL have parameter NumInstr, default 4: number of entries in the decode table OfflInstr.
REQ-004 SHALL have parameter OfflInstr, default all-zero: array [NumInstr] of acc_pkg::offl_instr_t, the accepted-instruction table.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset; asynchronous, active-low.
REQ-007 req_valid_i / req_ready_o  in / out  1 / 1  offload request handshake.
REQ-008 req_instr_i  input  32  offloaded instruction word.
REQ-009 req_rs_i  input  3 x DataWidth  source operands rs1, rs2, rs3.
REQ-010 req_id_i  input  IdWidth  request tag.
REQ-011 exe_valid_o / exe_ready_i  out / in  1 / 1  issue handshake to accelerator datapath.
REQ-012 exe_op_a_o, exe_op_b_o, exe_op_c_o  output  DataWidth each  resolved operands.
REQ-013 exe_idx_o  output  $clog2(NumInstr) (min 1)  index of matched table entry.
REQ-014 exe_instr_o  output  32  registered instruction word.
REQ-015 res_valid_i / res_ready_o  in / out  1 / 1  result handshake from datapath; res_data_i input DataWidth.
REQ-016 rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake to core; rsp_id_o IdWidth, rsp_data_o DataWidth, rsp_error_o 1.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_RES, RESP; one request in flight at a time.
REQ-018 IDLE: req_ready_o=1 (only in IDLE); on req_valid_i&req_ready_o SHALL register instr, rs1..rs3, id.
REQ-019 Decode: entry k matches when (instr & instr_mask)==instr_data; lowest matching index wins.
REQ-020 IDLE->ISSUE on accept with a match; IDLE->RESP on accept without match (rsp_error_o=1, rsp_data_o=0).
REQ-021 ISSUE: exe_valid_o=1 starting the cycle after accept; exe_* outputs SHALL stay stable until exe_ready_i.
REQ-022 On exe handshake: writeback!=0 -> WAIT_RES; writeback==0 -> IDLE, no response issued.
REQ-023 WAIT_RES: res_ready_o=1; on res_valid_i capture res_data_i -> RESP with rsp_error_o=0.
REQ-024 RESP: rsp_valid_o=1, rsp_id_o = registered id; outputs stable until rsp_ready_i, then -> IDLE.
REQ-025 Operand x in {a,b,c} (rs index 1,2,3): op_x_mux=OP_RS and use_rs[x-1]=1 -> rs; OP_RS with use_rs bit 0 -> 0; OP_IMM -> immediate per imm_x_mux; op_sel values 2,3 -> 0.
REQ-026 Immediates, sign-extended to DataWidth: I={i[31:20]}; S={i[31:25],i[11:7]}; B={i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'b0}; J={i[31],i[19:12],i[20],i[30:21],0}; imm_sel 5..7 -> 0.
REQ-027 Minimum latency: accept cycle N, exe_valid_o at N+1, rsp_valid_o at N+2 for unmatched, at (result cycle)+1 otherwise.
REQ-028 res_valid_i outside WAIT_RES SHALL be ignored (res_ready_o=0); req_valid_i outside IDLE SHALL not be accepted.

Reset
REQ-029 On rst_ni low, SHALL go to IDLE immediately, clearing all registers to 0; any in-flight request is dropped without response.
REQ-030 Reset values: req_ready_o=1, exe_valid_o=0, res_ready_o=0, rsp_valid_o=0, all data/id/idx outputs 0.

Verification
REQ-031 Table[0]={data 0x00000013, mask 0x0000707F, wb 01, use_rs 001, a=OP_RS, b=OP_IMM, imm_b=IMM_I}; req instr 0xFFF08093, rs1=5, id=3 -> next cycle exe_op_a=5, exe_op_b=0xFFFFFFFF, exe_idx=0; res_data 4 -> rsp id 3, data 4, error 0.
REQ-032 Req instr 0x00000000, id=7 (no entry matches) -> exe_valid_o never asserted; rsp_valid_o at N+2, id 7, data 0, error 1.
REQ-033 Hold exe_ready_i low 3 cycles, then rsp_ready_i low 2 cycles -> exe_*/rsp_* stable throughout; req_ready_o=0 until rsp handshake completes.
REQ-034 Matched entry with wb=00 -> exe handshake, then req_ready_o=1 next cycle, rsp_valid_o never asserted.
REQ-035 Entries 1 and 2 both match, entry 2 uses IMM_U -> exe_idx=1; separately instr 0x12345037 with IMM_U -> operand 0x12345000.
REQ-036 Assert rst_ni low during WAIT_RES -> all valids 0 asynchronously, req_ready_o=1, later res_valid_i ignored.

Source files
------------

// File: rtl/acc_offload_responder.sv
// Offload responder: accepts one instruction at a time, decodes it against a
// mask/match table, issues resolved operands to a datapath and returns a tagged response.
package acc_pkg;
  localparam logic [1:0] OP_RS  = 2'd0;
  localparam logic [1:0] OP_IMM = 2'd1;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic [31:0] instr_data;
    logic [31:0] instr_mask;
    logic [1:0]  writeback;
    logic [2:0]  use_rs;
    logic [1:0]  op_a_mux;
    logic [1:0]  op_b_mux;
    logic [1:0]  op_c_mux;
    logic [2:0]  imm_a_mux;
    logic [2:0]  imm_b_mux;
    logic [2:0]  imm_c_mux;
  } offl_instr_t;
endpackage

module acc_offload_responder #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4,
  parameter int NumInstr  = 4,
  parameter acc_pkg::offl_instr_t OfflInstr [NumInstr] = '{default: '0},
  localparam int IdxWidth = (NumInstr > 1) ? $clog2(NumInstr) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [31:0]                  req_instr_i,
  input  logic [2:0][DataWidth-1:0]    req_rs_i,
  input  logic [IdWidth-1:0]           req_id_i,
  output logic                         exe_valid_o,
  input  logic                         exe_ready_i,
  output logic [DataWidth-1:0]         exe_op_a_o,
  output logic [DataWidth-1:0]         exe_op_b_o,
  output logic [DataWidth-1:0]         exe_op_c_o,
  output logic [IdxWidth-1:0]          exe_idx_o,
  output logic [31:0]                  exe_instr_o,
  input  logic                         res_valid_i,
  output logic                         res_ready_o,
  input  logic [DataWidth-1:0]         res_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [IdWidth-1:0]           rsp_id_o,
  output logic [DataWidth-1:0]         rsp_data_o,
  output logic                         rsp_error_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_e;

  state_e                      state_q, state_d;
  logic                        rsp_hold_q, rsp_hold_d;
  logic [31:0]                 instr_q, instr_d;
  logic [IdWidth-1:0]          id_q, id_d;
  logic [IdxWidth-1:0]         idx_q, idx_d;
  logic [1:0]                  wb_q, wb_d;
  logic signed [DataWidth-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [DataWidth-1:0]        rsp_data_q, rsp_data_d;
  logic                        rsp_err_q, rsp_err_d;

  logic                        hit;
  logic [IdxWidth-1:0]         hit_idx;
  logic [1:0]                  hit_wb;
  logic signed [DataWidth-1:0] hit_a, hit_b, hit_c;

  function automatic logic signed [DataWidth-1:0] imm_gen(input logic [31:0] i,
                                                          input logic [2:0]  sel);
    logic signed [31:0] v;
    case (sel)
      acc_pkg::IMM_I: v = {{20{i[31]}}, i[31:20]};
      acc_pkg::IMM_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
      acc_pkg::IMM_B: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      acc_pkg::IMM_U: v = {i[31:12], 12'b0};
      acc_pkg::IMM_J: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:        v = '0;
    endcase
    return DataWidth'(v);
  endfunction

  function automatic logic signed [DataWidth-1:0] resolve(input logic [1:0]           sel,
                                                          input logic                 rs_en,
                                                          input logic [2:0]           isel,
                                                          input logic [31:0]          instr,
                                                          input logic [DataWidth-1:0] rs);
    case (sel)
      acc_pkg::OP_RS:  return rs_en ? $signed(rs) : '0;
      acc_pkg::OP_IMM: return imm_gen(instr, isel);
      default:         return '0;
    endcase
  endfunction

  // Descending scan so the lowest matching entry is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_wb  = '0;
    hit_a   = '0;
    hit_b   = '0;
    hit_c   = '0;
    for (int k = NumInstr - 1; k >= 0; k--) begin
      if ((req_instr_i & OfflInstr[k].instr_mask) == OfflInstr[k].instr_data) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(k);
        hit_wb  = OfflInstr[k].writeback;
        hit_a   = resolve(OfflInstr[k].op_a_mux, OfflInstr[k].use_rs[0],
                          OfflInstr[k].imm_a_mux, req_instr_i, req_rs_i[0]);
        hit_b   = resolve(OfflInstr[k].op_b_mux, OfflInstr[k].use_rs[1],
                          OfflInstr[k].imm_b_mux, req_instr_i, req_rs_i[1]);
        hit_c   = resolve(OfflInstr[k].op_c_mux, OfflInstr[k].use_rs[2],
                          OfflInstr[k].imm_c_mux, req_instr_i, req_rs_i[2]);
      end
    end
  end

  // rsp_hold delays an error response by one cycle so it surfaces two cycles after accept.
  always_comb begin
    state_d     = state_q;
    rsp_hold_d  = 1'b0;
    instr_d     = instr_q;
    id_d        = id_q;
    idx_d       = idx_q;
    wb_d        = wb_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = (state_q == IDLE);
    exe_valid_o = (state_q == ISSUE);
    res_ready_o = (state_q == WAIT_RES);
    rsp_valid_o = (state_q == RESP) && !rsp_hold_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          instr_d = req_instr_i;
          id_d    = req_id_i;
          if (hit) begin
            idx_d     = hit_idx;
            wb_d      = hit_wb;
            op_a_d    = hit_a;
            op_b_d    = hit_b;
            op_c_d    = hit_c;
            rsp_err_d = 1'b0;
            state_d   = ISSUE;
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_hold_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        if (exe_ready_i) state_d = (wb_q != 2'b00) ? WAIT_RES : IDLE;
      end
      WAIT_RES: begin
        if (res_valid_i) begin
          rsp_data_d = res_data_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (!rsp_hold_q && rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rsp_hold_q <= 1'b0;
      instr_q    <= '0;
      id_q       <= '0;
      idx_q      <= '0;
      wb_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_hold_q <= rsp_hold_d;
      instr_q    <= instr_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      wb_q       <= wb_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_c_q     <= op_c_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign exe_op_a_o  = op_a_q;
  assign exe_op_b_o  = op_b_q;
  assign exe_op_c_o  = op_c_q;
  assign exe_idx_o   = idx_q;
  assign exe_instr_o = instr_q;
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_error_o = rsp_err_q;

endmodule
